// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types, defaults and lane rotation for the data memory controller
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      SRC_DMEM = 1'b0,
      SRC_MMIO = 1'b1
   } rd_src_e;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hAAAAA000;

   // Rotate LSB-justified store data left by whole bytes so each byte lands on
   // the lane its address selects; bytes pushed past lane 3 wrap to lane 0.
   function automatic logic [31:0] lane_rotate(input logic [31:0] din, input logic [1:0] ofs);
      case (ofs)
         2'd0:    return din;
         2'd1:    return {din[23:0], din[31:24]};
         2'd2:    return {din[15:0], din[31:16]};
         default: return {din[7:0],  din[31:8]};
      endcase
   endfunction

endpackage

// File: rtl/dmem_bram.sv
// rtl/dmem_bram.sv - 4-lane byte-enabled synchronous read-first data RAM
module dmem_bram #(
   parameter int unsigned AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [31:0] mem [0:DEPTH-1];
   logic [31:0] rdata_d;
   logic [31:0] rdata_q;

   // Array is sampled before the write below lands, so collisions return old data.
   always_comb begin
      rdata_d = mem[addr];
   end

   // Read register; only this output register is cleared, never the array.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= 32'h0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // Per-lane byte writes.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data-side memory controller: byte-enabled DMEM plus stalled MMIO handshake
module data_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned DMEM_ADDR_BITS = 12,
   parameter logic [31:0] MMIO_BASE      = MMIO_BASE_DEFAULT,
   parameter int unsigned MMIO_TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        dbg,
   input  logic        mem_wea,
   input  logic        mem_rea,
   input  logic [3:0]  mem_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_din,
   output logic [31:0] mem_dout,
   output logic        mem_hold,
   output logic        mmio_req,
   output logic        mmio_we,
   output logic [11:0] mmio_addr,
   output logic [3:0]  mmio_be,
   output logic [31:0] mmio_wdata,
   input  logic        mmio_ack,
   input  logic [31:0] mmio_rdata,
   output logic        mmio_timeout
);

   localparam int unsigned       CNT_W     = $clog2(MMIO_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  TMO_LIMIT = CNT_W'(MMIO_TIMEOUT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      mmio_data_q, mmio_data_d;
   rd_src_e          rd_src_q, rd_src_d;
   logic             timeout_q, timeout_d;

   logic             mmio_sel;
   logic             issue;
   logic             dmem_we;
   logic [31:0]      wdata;
   logic [31:0]      ram_rdata;

   assign mmio_sel = (mem_addr[31:12] == MMIO_BASE[31:12]);
   assign issue    = mmio_sel && (mem_rea || mem_wea) && !dbg;
   assign dmem_we  = mem_wea && !mmio_sel && !dbg;
   assign wdata    = lane_rotate(mem_din, mem_addr[1:0]);

   dmem_bram #(
      .AW (DMEM_ADDR_BITS - 2)
   ) u_dmem (
      .clk   (clk),
      .rst   (Rst),
      .we    (dmem_we),
      .be    (mem_en),
      .addr  (mem_addr[DMEM_ADDR_BITS-1:2]),
      .wdata (wdata),
      .rdata (ram_rdata)
   );

   // State and capture registers.
   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mmio_data_q <= 32'h0;
         rd_src_q    <= SRC_DMEM;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mmio_data_q <= mmio_data_d;
         rd_src_q    <= rd_src_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next state: issue from IDLE, wait for ack or timeout, one release cycle in DONE.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mmio_data_d = mmio_data_q;
      rd_src_d    = SRC_DMEM;
      timeout_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (issue) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (mmio_ack) begin
               mmio_data_d = mem_wea ? 32'h0 : mmio_rdata;
               state_d     = DONE;
            end else if (cnt_d == TMO_LIMIT) begin
               mmio_data_d = 32'h0;
               timeout_d   = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            rd_src_d = SRC_MMIO;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake outputs; request fields follow the held pipeline request while req is up.
   always_comb begin
      mmio_req = 1'b0;
      mem_hold = 1'b0;
      case (state_q)
         IDLE: begin
            mmio_req = issue;
            mem_hold = issue;
         end
         WAIT: begin
            mmio_req = 1'b1;
            mem_hold = 1'b1;
         end
         default: begin
            mmio_req = 1'b0;
            mem_hold = 1'b0;
         end
      endcase
      mmio_we    = mmio_req && mem_wea;
      mmio_addr  = mmio_req ? mem_addr[11:0] : 12'h0;
      mmio_be    = mmio_req ? mem_en : 4'h0;
      mmio_wdata = mmio_req ? wdata : 32'h0;
   end

   assign mem_dout     = (rd_src_q == SRC_MMIO) ? mmio_data_q : ram_rdata;
   assign mmio_timeout = timeout_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

   logic        clk;
   logic        Rst;
   logic        dbg;
   logic        mem_wea;
   logic        mem_rea;
   logic [3:0]  mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        mem_hold;
   logic        mmio_req;
   logic        mmio_we;
   logic [11:0] mmio_addr;
   logic [3:0]  mmio_be;
   logic [31:0] mmio_wdata;
   logic        mmio_ack;
   logic [31:0] mmio_rdata;
   logic        mmio_timeout;

   int checks = 0;
   int fails  = 0;

   data_mem_ctrl dut (
      .clk          (clk),
      .Rst          (Rst),
      .dbg          (dbg),
      .mem_wea      (mem_wea),
      .mem_rea      (mem_rea),
      .mem_en       (mem_en),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout),
      .mem_hold     (mem_hold),
      .mmio_req     (mmio_req),
      .mmio_we      (mmio_we),
      .mmio_addr    (mmio_addr),
      .mmio_be      (mmio_be),
      .mmio_wdata   (mmio_wdata),
      .mmio_ack     (mmio_ack),
      .mmio_rdata   (mmio_rdata),
      .mmio_timeout (mmio_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic re, input logic [3:0] en,
                        input logic [31:0] addr, input logic [31:0] din);
      mem_wea  = we;
      mem_rea  = re;
      mem_en   = en;
      mem_addr = addr;
      mem_din  = din;
   endtask

   // Runs one MMIO access to completion; ack_at = 0 means the peripheral never answers.
   task automatic mmio_access(input logic we, input logic [31:0] addr, input logic [3:0] en,
                              input logic [31:0] din, input int ack_at, input logic [31:0] rd,
                              output int holds, output int bursts, output int pulses,
                              output logic done_req, output logic [31:0] dout_after,
                              output logic we_seen, output logic [11:0] addr_seen,
                              output logic [3:0] be_seen, output logic [31:0] wd_seen);
      logic prev_req;
      int   n;
      holds = 0; bursts = 0; pulses = 0; prev_req = 1'b0; n = 0;
      we_seen = 1'b0; addr_seen = 12'h0; be_seen = 4'h0; wd_seen = 32'h0;
      drive(we, !we, en, addr, din);
      #1;
      while (mem_hold && n < 400) begin
         holds++;
         if (mmio_req && !prev_req) bursts++;
         prev_req  = mmio_req;
         we_seen   = mmio_we;
         addr_seen = mmio_addr;
         be_seen   = mmio_be;
         wd_seen   = mmio_wdata;
         if (mmio_timeout) pulses++;
         if (ack_at != 0 && holds == ack_at + 1) begin
            mmio_ack   = 1'b1;
            mmio_rdata = rd;
         end
         cyc();
         mmio_ack   = 1'b0;
         mmio_rdata = 32'h0;
         #1;
         n++;
      end
      done_req = mmio_req;
      if (mmio_timeout) pulses++;
      cyc();
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      if (mmio_timeout) pulses++;
      dout_after = mem_dout;
   endtask

   int          holds, bursts, pulses;
   logic        done_req, we_seen;
   logic [31:0] dout_after, wd_seen;
   logic [11:0] addr_seen;
   logic [3:0]  be_seen;

   initial begin
      Rst = 1'b1; dbg = 1'b0; mmio_ack = 1'b0; mmio_rdata = 32'h0;
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      cyc();
      cyc();
      check("reset_dout", mem_dout, 32'h0);
      check("reset_req", 32'(mmio_req), 32'h0);
      check("reset_hold", 32'(mem_hold), 32'h0);
      check("reset_timeout", 32'(mmio_timeout), 32'h0);
      Rst = 1'b0;

      drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h11223344);
      #1;
      check("sw_hold", 32'(mem_hold), 32'h0);
      cyc();
      drive(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      #1;
      check("lw_hold", 32'(mem_hold), 32'h0);
      cyc();
      check("lw_0x10", mem_dout, 32'h11223344);
      cyc();
      check("en_without_we", mem_dout, 32'h11223344);

      dbg = 1'b1;
      drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      cyc();
      dbg = 1'b0;
      drive(1'b0, 1'b1, 4'hF, 32'h10, 32'h0);
      cyc();
      check("dbg_blocks_write", mem_dout, 32'h11223344);

      drive(1'b1, 1'b0, 4'h8, 32'h13, 32'h000000AB);
      cyc();
      drive(1'b0, 1'b1, 4'hF, 32'h10, 32'h0);
      cyc();
      check("sb_0x13", mem_dout, 32'hAB223344);

      drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      cyc();
      drive(1'b1, 1'b0, 4'h9, 32'h23, 32'h0000CDEF);
      cyc();
      drive(1'b0, 1'b1, 4'hF, 32'h20, 32'h0);
      cyc();
      check("sh_0x23_wrap", mem_dout, 32'hEF0000CD);

      drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h12345678);
      cyc();
      check("read_first", mem_dout, 32'hEF0000CD);
      drive(1'b0, 1'b1, 4'hF, 32'h20, 32'h0);
      cyc();
      check("after_collision", mem_dout, 32'h12345678);

      dbg = 1'b1;
      drive(1'b0, 1'b1, 4'hF, 32'hAAAAA008, 32'h0);
      #1;
      check("dbg_no_req", 32'(mmio_req), 32'h0);
      check("dbg_no_hold", 32'(mem_hold), 32'h0);
      dbg = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      cyc();

      mmio_access(1'b1, 32'hAAAAA006, 4'hC, 32'h00001234, 1, 32'h00000077,
                  holds, bursts, pulses, done_req, dout_after, we_seen, addr_seen, be_seen, wd_seen);
      check("mw_holds", 32'(holds), 32'd2);
      check("mw_we", 32'(we_seen), 32'h1);
      check("mw_addr", 32'(addr_seen), 32'h006);
      check("mw_be", 32'(be_seen), 32'hC);
      check("mw_wdata", wd_seen, 32'h12340000);
      check("mw_dout", dout_after, 32'h0);

      mmio_access(1'b0, 32'hAAAAA008, 4'hF, 32'h0, 3, 32'h0000005A,
                  holds, bursts, pulses, done_req, dout_after, we_seen, addr_seen, be_seen, wd_seen);
      check("mr_holds", 32'(holds), 32'd4);
      check("mr_bursts", 32'(bursts), 32'd1);
      check("mr_done_req", 32'(done_req), 32'h0);
      check("mr_we", 32'(we_seen), 32'h0);
      check("mr_addr", 32'(addr_seen), 32'h008);
      check("mr_pulses", 32'(pulses), 32'd0);
      check("mr_dout", dout_after, 32'h0000005A);

      mmio_access(1'b1, 32'hAAAAA004, 4'hF, 32'h00000041, 0, 32'h0,
                  holds, bursts, pulses, done_req, dout_after, we_seen, addr_seen, be_seen, wd_seen);
      check("to_holds", 32'(holds), 32'd256);
      check("to_pulses", 32'(pulses), 32'd1);
      check("to_wdata", wd_seen, 32'h00000041);
      check("to_done_req", 32'(done_req), 32'h0);
      check("to_dout", dout_after, 32'h0);
      check("to_hold_released", 32'(mem_hold), 32'h0);

      drive(1'b0, 1'b1, 4'hF, 32'hAAAAA00C, 32'h0);
      cyc();
      check("rst_wait_req", 32'(mmio_req), 32'h1);
      Rst = 1'b1;
      cyc();
      Rst = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      mmio_ack   = 1'b1;
      mmio_rdata = 32'h00000099;
      #1;
      check("rst_req_dropped", 32'(mmio_req), 32'h0);
      check("rst_hold_dropped", 32'(mem_hold), 32'h0);
      check("rst_dout", mem_dout, 32'h0);
      cyc();
      mmio_ack   = 1'b0;
      mmio_rdata = 32'h0;
      #1;
      check("late_ack_req", 32'(mmio_req), 32'h0);
      check("late_ack_hold", 32'(mem_hold), 32'h0);
      check("late_ack_timeout", 32'(mmio_timeout), 32'h0);
      drive(1'b0, 1'b1, 4'hF, 32'h10, 32'h0);
      cyc();
      check("dmem_kept_over_reset", mem_dout, 32'hAB223344);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
